tone_sequencer: RTL and testbench
=================================

# tone_sequencer

Programmable melody sequencer that plays a stored list of notes as a square wave on a buzzer pin. It sits directly downstream of the generic frequency divider: the divider's slow square-wave output (for example a 2 Hz tempo) drives `tick`. Each rising edge of `tick` is one beat. The sequencer generates the audio tone itself with a runtime-programmable half-period counter on the 12 MHz system clock.

## Interface
Parameters:
- `NOTES`, default 8: number of note-table entries; `AW = $clog2(NOTES)`, minimum 1.
- `PW`, default 16: width of the half-period field, in clock cycles.
- `DW`, default 4: width of the duration field, in beats.

Ports:
- `clk_in`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  beat strobe from the upstream divider; a level signal whose rising edge marks one beat.
- `start`  in  1  begin playback at entry 0; sampled on the clock edge.
- `stop`  in  1  abort playback.
- `loop`  in  1  level; restart at entry 0 after the last note. Present only with `TONE_SEQ_LOOP_EN`.
- `wr_en`  in  1  note-table write strobe.
- `wr_addr`  in  AW  note-table write address.
- `wr_data`  in  PW+DW  note-table write data: `{dur[DW-1:0], period[PW-1:0]}`.
- `tone`  out  1  square-wave audio output.
- `busy`  out  1  high while in LOAD or PLAY.
- `note_idx`  out  AW  index of the current entry.
- `done`  out  1  one-cycle pulse on natural end of the sequence.

## Operation
- Note table: `NOTES` × (PW+DW) register array.
  - Written on `wr_en` at any time.
  - Not affected by `rst`; initialised to all zeros at configuration.
- Entry format:
  - `period` = half-period in clocks; `period == 0` is a rest (tone held 0).
  - `dur` = length in beats; `dur == 0` is the end-of-sequence terminator.
- Beat detect: `tick_q <= tick` every clock; `tick_rise = tick & ~tick_q`. Beats are counted in PLAY only.
- FSM states: IDLE, LOAD, PLAY.
- IDLE:
  - `tone = 0`, `busy = 0`.
  - `start` → LOAD with `note_idx = 0`.
- LOAD (exactly one cycle):
  - Latch the entry at `note_idx` into `cur_period` and `beats_left`.
  - Clear the half-period counter; `tone = 0`.
  - If `dur == 0`, end the sequence (see below); otherwise → PLAY.
- PLAY:
  - Tone generation when `cur_period != 0`:
    - `hcnt` increments every clock.
    - When `hcnt == cur_period - 1`: `hcnt <= 0` and `tone` toggles.
    - `period == 1` toggles every clock.
  - Tone during a rest: held 0.
  - On `tick_rise`, `beats_left` decrements. When it was 1, the note ends:
    - If `note_idx == NOTES-1`, end the sequence.
    - Otherwise `note_idx + 1` → LOAD.
- End of sequence:
  - Pulse `done` for one cycle and go to IDLE.
  - `note_idx` keeps the index of the terminator or last entry.
- `stop` in any state:
  - Next state is IDLE, `tone = 0`, no `done`.
  - `stop` wins over a simultaneous `start`.
- `start` while `busy` is ignored.
- A write to the address being read in LOAD on the same edge: LOAD latches the old contents. Writes to the playing entry take effect the next time that entry is loaded.
- `rst` mid-playback: immediate return to IDLE with all outputs at reset values; table contents are preserved.
- Reset values: `tone 0`, `busy 0`, `done 0`, `note_idx 0`, `tick_q 0`, state IDLE.

## Timing
- `start` sampled high at edge k:
  - LOAD after edge k.
  - PLAY after edge k+1, with `hcnt = 0` and `tone = 0`.
  - First `tone` rise at edge k+1+period.
- `busy` rises after edge k.
- Beat latency:
  - `tick` high first sampled at edge t (with `tick_q == 0`) is counted at edge t.
  - A note ending at edge t is in LOAD after t and plays the next note after t+1.
  - Gap between notes: one cycle of `tone = 0`.
- `done` is high for the single cycle after the terminating edge; `busy` falls at the same edge.
- `stop` at edge s: IDLE and `tone = 0` after edge s.

## Configuration
- Macro: `TONE_SEQ_LOOP_EN`.
- Defined:
  - The `loop` port exists.
  - At end of sequence with `loop = 1`: go to LOAD with `note_idx = 0`, no `done`, `busy` stays 1.
  - With `loop = 0`: same behaviour as undefined.
- Undefined: no `loop` port; the sequence always ends with `done` and IDLE.

## Test plan
- Scale playback:
  - Stimulus: table {dur 2, period 6000}, {dur 1, period 4000}, {dur 0}; tick period 1000 clocks; pulse `start`.
  - Response: `tone` half-period 6000 clocks for 2 beats, then 4000 clocks for 1 beat; `done` pulses once; `busy` returns to 0.
- Rest and period 1:
  - Stimulus: entry {dur 1, period 0}, then {dur 1, period 1}, then {dur 0}.
  - Response: `tone` stays 0 for one beat, then toggles every clock for one beat.
- Stop and start priority:
  - Stimulus: assert `stop` mid-note; separately, assert `start` and `stop` in the same cycle.
  - Response: IDLE and `tone = 0` the next cycle, `done` never pulses; the simultaneous case stays IDLE.
- Full table, no terminator:
  - Stimulus: all 8 entries with `dur = 1`.
  - Response: `note_idx` steps 0..7; `done` pulses after the 8th beat; `note_idx = 7`.
- Async reset:
  - Stimulus: assert `rst` between clock edges during PLAY.
  - Response: all outputs go to reset values immediately; a following `start` replays the unchanged table.
- Loop (`TONE_SEQ_LOOP_EN` defined):
  - Stimulus: `loop = 1` with a 2-note sequence.
  - Response: `note_idx` goes 0, 1, 0, 1..., no `done`; dropping `loop` ends the sequence at the next terminator.

Source files
------------

// File: rtl/tone_sequencer.sv
// Note-table melody sequencer: plays {dur, period} entries as a square wave, one beat per tick rise.
// Optional feature macro TONE_SEQ_LOOP_EN adds the loop port (restart at entry 0 instead of ending).
module tone_sequencer #(
  parameter int NOTES = 8,
  parameter int PW    = 16,
  parameter int DW    = 4,
  localparam int AW   = (NOTES > 1) ? $clog2(NOTES) : 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
`ifdef TONE_SEQ_LOOP_EN
  input  logic             loop,
`endif
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PW+DW-1:0] wr_data,
  output logic             tone,
  output logic             busy,
  output logic [AW-1:0]    note_idx,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    note_idx_q, note_idx_d;
  logic [PW-1:0]    cur_period_q, cur_period_d;
  logic [DW-1:0]    beats_left_q, beats_left_d;
  logic [PW-1:0]    hcnt_q, hcnt_d;
  logic             tone_q, tone_d;
  logic             done_q, done_d;
  logic             tick_q;
  logic             tick_rise;
  logic             seq_end;

  logic [PW+DW-1:0] table_q [NOTES];
  logic [PW+DW-1:0] rd_entry;
  logic [PW-1:0]    rd_period;
  logic [DW-1:0]    rd_dur;
  logic             last_entry;

  // Table has no reset so contents survive rst; a same-edge write is seen by the next LOAD only.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  assign rd_entry   = table_q[note_idx_q];
  assign rd_period  = rd_entry[PW-1:0];
  assign rd_dur     = rd_entry[PW+DW-1:PW];
  assign last_entry = (note_idx_q == AW'(NOTES - 1));
  assign tick_rise  = tick & ~tick_q;

  always_comb begin
    state_d      = state_q;
    note_idx_d   = note_idx_q;
    cur_period_d = cur_period_q;
    beats_left_d = beats_left_q;
    hcnt_d       = hcnt_q;
    tone_d       = tone_q;
    done_d       = 1'b0;
    seq_end      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tone_d = 1'b0;
        if (start) begin
          state_d    = S_LOAD;
          note_idx_d = '0;
        end
      end

      S_LOAD: begin
        cur_period_d = rd_period;
        beats_left_d = rd_dur;
        hcnt_d       = '0;
        tone_d       = 1'b0;
        if (rd_dur == '0) begin
          seq_end = 1'b1;
        end else begin
          state_d = S_PLAY;
        end
      end

      S_PLAY: begin
        if (cur_period_q != '0) begin
          if (hcnt_q == cur_period_q - PW'(1)) begin
            hcnt_d = '0;
            tone_d = ~tone_q;
          end else begin
            hcnt_d = hcnt_q + PW'(1);
          end
        end else begin
          tone_d = 1'b0;
        end

        if (tick_rise) begin
          beats_left_d = beats_left_q - DW'(1);
          if (beats_left_q == DW'(1)) begin
            tone_d = 1'b0;
            if (last_entry) begin
              seq_end = 1'b1;
            end else begin
              note_idx_d = note_idx_q + AW'(1);
              state_d    = S_LOAD;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tone_d  = 1'b0;
      end
    endcase

    if (seq_end) begin
      tone_d = 1'b0;
`ifdef TONE_SEQ_LOOP_EN
      if (loop) begin
        state_d    = S_LOAD;
        note_idx_d = '0;
      end else begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
`else
      state_d = S_IDLE;
      done_d  = 1'b1;
`endif
    end

    // stop overrides everything, including a same-cycle start or end of sequence.
    if (stop) begin
      state_d    = S_IDLE;
      note_idx_d = note_idx_q;
      tone_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      note_idx_q   <= '0;
      cur_period_q <= '0;
      beats_left_q <= '0;
      hcnt_q       <= '0;
      tone_q       <= 1'b0;
      done_q       <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      note_idx_q   <= note_idx_d;
      cur_period_q <= cur_period_d;
      beats_left_q <= beats_left_d;
      hcnt_q       <= hcnt_d;
      tone_q       <= tone_d;
      done_q       <= done_d;
      tick_q       <= tick;
    end
  end

  assign tone     = tone_q;
  assign busy     = (state_q != S_IDLE);
  assign note_idx = note_idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: per-cycle vector table plus hand sequences
// for full-table playback, async reset and (with TONE_SEQ_LOOP_EN) looping.
module tb_tone_sequencer;

  localparam int NOTES = 8;
  localparam int PW    = 16;
  localparam int DW    = 4;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick;
  logic             start;
  logic             stop;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [PW+DW-1:0] wr_data;
  logic             tone;
  logic             busy;
  logic [AW-1:0]    note_idx;
  logic             done;
`ifdef TONE_SEQ_LOOP_EN
  logic             loop;
`endif

  always #5 clk = ~clk;

  tone_sequencer #(.NOTES(NOTES), .PW(PW), .DW(DW)) dut (
    .clk_in   (clk),
    .rst      (rst),
    .tick     (tick),
    .start    (start),
    .stop     (stop),
`ifdef TONE_SEQ_LOOP_EN
    .loop     (loop),
`endif
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .tone     (tone),
    .busy     (busy),
    .note_idx (note_idx),
    .done     (done)
  );

  typedef struct {
    logic          st;
    logic          sp;
    logic          tk;
    logic          we;
    logic [AW-1:0] wa;
    logic [PW+DW-1:0] wd;
    logic          e_tone;
    logic          e_busy;
    logic          e_done;
    logic [AW-1:0] e_idx;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  vec_t vt [30];

  function automatic vec_t mv(input logic st, input logic sp, input logic tk, input logic we,
                              input int wa, input int dur, input int per,
                              input logic et, input logic eb, input logic ed, input int ei);
    vec_t v;
    v.st = st; v.sp = sp; v.tk = tk; v.we = we;
    v.wa = wa[AW-1:0];
    v.wd = {dur[DW-1:0], per[PW-1:0]};
    v.e_tone = et; v.e_busy = eb; v.e_done = ed;
    v.e_idx = ei[AW-1:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic et, input logic eb, input logic ed, input int ei);
    chk({tag, " tone"}, 32'(tone), 32'(et));
    chk({tag, " busy"}, 32'(busy), 32'(eb));
    chk({tag, " done"}, 32'(done), 32'(ed));
    chk({tag, " idx"},  32'(note_idx), 32'(ei));
  endtask

  task automatic step(input logic s, input logic p, input logic t);
    start = s;
    stop  = p;
    tick  = t;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int dur, input int per);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = {dur[DW-1:0], per[PW-1:0]};
    step(1'b0, 1'b0, 1'b0);
    wr_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`ifdef TONE_SEQ_LOOP_EN
    loop = 1'b0;
`endif
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 0);
    #8 rst = 1'b0;
    @(posedge clk);
    #1;

    // Scale with a rest and a period-1 note, then terminator.
    wr(0, 2, 3);
    wr(1, 1, 0);
    wr(2, 1, 1);
    wr(3, 0, 0);

    //           st sp tk we wa dur per   tone busy done idx
    vt[0]  = mv(1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    vt[1]  = mv(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    vt[2]  = mv(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    vt[3]  = mv(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    vt[4]  = mv(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0);
    vt[5]  = mv(1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0);
    vt[6]  = mv(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0);
    vt[7]  = mv(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    vt[8]  = mv(0, 0, 1, 0, 0, 0, 0,   0, 1, 0, 0);
    vt[9]  = mv(0, 0, 1, 0, 0, 0, 0,   0, 1, 0, 0);
    vt[10] = mv(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0);
    vt[11] = mv(0, 0, 1, 0, 0, 0, 0,   0, 1, 0, 1);
    vt[12] = mv(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1);
    vt[13] = mv(1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1);
    vt[14] = mv(0, 0, 1, 0, 0, 0, 0,   0, 1, 0, 2);
    vt[15] = mv(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 2);
    vt[16] = mv(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 2);
    vt[17] = mv(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 2);
    vt[18] = mv(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 2);
    vt[19] = mv(0, 0, 1, 0, 0, 0, 0,   0, 1, 0, 3);
    vt[20] = mv(0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 3);
    vt[21] = mv(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 3);
    vt[22] = mv(1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 3);
    vt[23] = mv(1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    vt[24] = mv(0, 0, 0, 1, 0, 1, 2,   0, 1, 0, 0);
    vt[25] = mv(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    vt[26] = mv(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    vt[27] = mv(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0);
    vt[28] = mv(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    vt[29] = mv(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      wr_en   = vt[i].we;
      wr_addr = vt[i].wa;
      wr_data = vt[i].wd;
      step(vt[i].st, vt[i].sp, vt[i].tk);
      wr_en   = 1'b0;
      chk_out($sformatf("vec%0d", i), vt[i].e_tone, vt[i].e_busy, vt[i].e_done, 32'(vt[i].e_idx));
    end

    // Full table without terminator: one beat per entry, period = index+1.
    for (int i = 0; i < NOTES; i++) wr(i, 1, i + 1);
    step(1'b1, 1'b0, 1'b0);
    chk_out("full load0", 1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NOTES; i++) begin
      chk($sformatf("full play%0d idx", i), 32'(note_idx), 32'(i));
      chk($sformatf("full play%0d busy", i), 32'(busy), 32'd1);
      step(1'b0, 1'b0, 1'b1);
      if (i < NOTES - 1) begin
        chk_out($sformatf("full next%0d", i), 1'b0, 1'b1, 1'b0, i + 1);
      end else begin
        chk_out("full end", 1'b0, 1'b0, 1'b1, NOTES - 1);
      end
      step(1'b0, 1'b0, 1'b0);
    end
    chk_out("full after", 1'b0, 1'b0, 1'b0, NOTES - 1);

    // Async reset mid-note, then replay the preserved table.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_out("prerst", 1'b1, 1'b1, 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    chk_out("async rst", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_out("rst idle", 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0);
    chk_out("replay load", 1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_out("replay p1", 1'b1, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1);
    chk_out("replay next", 1'b0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_out("replay p2 lo", 1'b0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 1'b0);
    chk_out("replay p2 hi", 1'b1, 1'b1, 1'b0, 1);
    step(1'b0, 1'b1, 1'b0);
    chk_out("replay stop", 1'b0, 1'b0, 1'b0, 1);

`ifdef TONE_SEQ_LOOP_EN
    wr(0, 1, 1);
    wr(1, 1, 1);
    wr(2, 0, 0);
    loop = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      chk_out($sformatf("loop%0d play0", r), 1'b0, 1'b1, 1'b0, 0);
      step(1'b0, 1'b0, 1'b1);
      chk_out($sformatf("loop%0d load1", r), 1'b0, 1'b1, 1'b0, 1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      chk_out($sformatf("loop%0d load2", r), 1'b0, 1'b1, 1'b0, 2);
      step(1'b0, 1'b0, 1'b0);
      chk_out($sformatf("loop%0d wrap", r), 1'b0, 1'b1, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0);
    end
    loop = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk_out("loop off end", 1'b0, 1'b0, 1'b1, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
